spi_slave_regfile: RTL and testbench

//  SPI mode-0 slave that receives host commands and writes the seven 8-bit display registers slv_reg0..slv_reg6

---
 rtl/spi_slave_regfile.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave writing the seven display registers, with read-back over MISO; all SPI pins oversampled in clk.
// Optional build macro SPI_AUTOINC_EN: address advances after every data byte (burst access).
module spi_slave_regfile #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic [7:0] slv_reg0,
    output logic [7:0] slv_reg1,
    output logic [7:0] slv_reg2,
    output logic [7:0] slv_reg3,
    output logic [7:0] slv_reg4,
    output logic [7:0] slv_reg5,
    output logic [7:0] slv_reg6,
    output logic       wr_stb,
    output logic [2:0] wr_addr,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic                   byte_done_q, byte_done_d;
    logic                   rw_q, rw_d;
    logic [2:0]             addr_q, addr_d;
    logic                   acted_q, acted_d;
    logic [6:0][7:0]        regs_q, regs_d;
    logic                   wr_stb_q, wr_stb_d;
    logic [2:0]             wr_addr_q, wr_addr_d;
    logic                   miso_q, miso_d;

    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall;
    logic [7:0][7:0]        rd_tbl;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // Address 7 has no register behind it and always reads as zero.
    assign rd_tbl    = {8'h00, regs_q};

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        sclk_prev_d = sclk_s;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        byte_done_d = 1'b0;
        rw_d        = rw_q;
        addr_d      = addr_q;
        acted_d     = acted_q;
        regs_d      = regs_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        miso_d      = ss_s ? 1'b0 : tx_q[7];

        if (ss_s) begin
            // Deselect aborts any partial byte and returns to idle.
            state_d = IDLE;
            cnt_d   = 3'd0;
            tx_d    = 8'h00;
            acted_d = 1'b0;
        end else begin
            if (state_q == IDLE)
                state_d = CMD;
            if (sclk_rise) begin
                rx_d        = {rx_q[6:0], mosi_s};
                cnt_d       = cnt_q + 3'd1;
                byte_done_d = (cnt_q == 3'd7);
            end
            // No shift on the fall just after a byte boundary: the freshly loaded MSB must stay put.
            if (sclk_fall && cnt_q != 3'd0)
                tx_d = {tx_q[6:0], 1'b0};
            if (byte_done_q) begin
                if (state_q == CMD) begin
                    rw_d    = rx_q[7];
                    addr_d  = rx_q[2:0];
                    acted_d = 1'b0;
                    state_d = DATA;
                    if (!rx_q[7])
                        tx_d = rd_tbl[rx_q[2:0]];
                end else if (state_q == DATA) begin
`ifdef SPI_AUTOINC_EN
                    if (rw_q) begin
                        if (addr_q != 3'd7) begin
                            regs_d[addr_q] = rx_q;
                            wr_stb_d       = 1'b1;
                            wr_addr_d      = addr_q;
                        end
                    end else begin
                        tx_d = rd_tbl[(addr_q == 3'd6) ? 3'd0 : addr_q + 3'd1];
                    end
                    addr_d = (addr_q == 3'd6) ? 3'd0 : addr_q + 3'd1;
`else
                    if (rw_q) begin
                        if (!acted_q && addr_q != 3'd7) begin
                            regs_d[addr_q] = rx_q;
                            wr_stb_d       = 1'b1;
                            wr_addr_d      = addr_q;
                        end
                    end else begin
                        tx_d = rd_tbl[addr_q];
                    end
                    acted_d = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cnt_q       <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= 3'd0;
            acted_q     <= 1'b0;
            regs_q      <= {7{RESET_VAL}};
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 3'd0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            acted_q     <= acted_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            miso_q      <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign wr_stb   = wr_stb_q;
    assign wr_addr  = wr_addr_q;
    assign busy     = ~ss_s;
    assign slv_reg0 = regs_q[0];
    assign slv_reg1 = regs_q[1];
    assign slv_reg2 = regs_q[2];
    assign slv_reg3 = regs_q[3];
    assign slv_reg4 = regs_q[4];
    assign slv_reg5 = regs_q[5];
    assign slv_reg6 = regs_q[6];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: expected writes/reads are queued by the stimulus and checked by a monitor.
module tb_spi_slave_regfile;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    logic       miso, wr_stb, busy;
    logic [2:0] wr_addr;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6;

    spi_slave_regfile dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso),
        .slv_reg0(r0), .slv_reg1(r1), .slv_reg2(r2), .slv_reg3(r3),
        .slv_reg4(r4), .slv_reg5(r5), .slv_reg6(r6),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] model [7];
    logic [10:0] wq[$];   // {addr, data}
    logic [7:0] rq[$];    // expected read bytes
    logic [7:0] got_q[$]; // bytes the host received

    function automatic logic [7:0] dut_reg(input logic [2:0] a);
        case (a)
            3'd0: return r0; 3'd1: return r1; 3'd2: return r2; 3'd3: return r3;
            3'd4: return r4; 3'd5: return r5; 3'd6: return r6; default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 7; i++)
            chk($sformatf("%s_reg%0d", tag, i), dut_reg(3'(i)), model[i]);
    endtask

    // Monitor: every wr_stb must match the next queued write; every host byte the next queued read.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_stb) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_stb_unexpected: got addr %0d expected none", wr_addr);
                end else begin
                    logic [10:0] e;
                    e = wq.pop_front();
                    chk("wr_addr", {5'd0, wr_addr}, {5'd0, e[10:8]});
                    chk("wr_data", dut_reg(wr_addr), e[7:0]);
                end
            end
            if (got_q.size() > 0) begin
                logic [7:0] g;
                g = got_q.pop_front();
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got %h expected none", g);
                end else begin
                    chk("rd_data", g, rq.pop_front());
                end
            end
        end
    end

    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = d[i];
            #80;
            rx[i] = miso;
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
        end
    endtask

    task automatic exp_wr(input logic [2:0] a, input logic [7:0] d);
        wq.push_back({a, d});
        model[a] = d;
    endtask

    // Frame of full bytes; bytes after the command are pushed to got_q when is_read.
    task automatic frame(input logic [7:0] b [], input bit is_read);
        logic [7:0] rx;
        ss_n = 1'b0;
        #100;
        for (int i = 0; i < b.size(); i++) begin
            spi_bits(b[i], 8, rx);
            if (is_read && i > 0) got_q.push_back(rx);
        end
        #100;
        ss_n = 1'b1;
        #300;
    endtask

    initial begin
        logic [7:0] rx;
        for (int i = 0; i < 7; i++) model[i] = 8'h00;

        // reset state
        #23;
        chk("rst_miso", {7'd0, miso}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_wr_stb", {7'd0, wr_stb}, 8'h00);
        chk("rst_wr_addr", {5'd0, wr_addr}, 8'h00);
        chk_regs("rst");
        reset = 1'b1;
        #50;

        // single write
        exp_wr(3'd3, 8'hA5);
        frame('{8'h83, 8'hA5}, 1'b0);
        chk_regs("wr3");

        // preload then read back
        exp_wr(3'd5, 8'h3C);
        frame('{8'h85, 8'h3C}, 1'b0);
        rq.push_back(8'h3C);
        frame('{8'h05, 8'h00}, 1'b1);
        chk_regs("rd5");

        // burst write
        exp_wr(3'd5, 8'h11);
`ifdef SPI_AUTOINC_EN
        exp_wr(3'd6, 8'h22);
        exp_wr(3'd0, 8'h33);
`endif
        frame('{8'h85, 8'h11, 8'h22, 8'h33}, 1'b0);
        chk_regs("burst");

        // aborted mid-byte write, then a complete one
        ss_n = 1'b0;
        #100;
        spi_bits(8'h81, 8, rx);
        spi_bits(8'hF0, 4, rx);
        #100;
        ss_n = 1'b1;
        #300;
        chk_regs("abort");
        exp_wr(3'd1, 8'h7E);
        frame('{8'h81, 8'h7E}, 1'b0);
        chk_regs("wr1");

        // address 7: no write, reads zero; reserved bits ignored on the write
        frame('{8'h87, 8'hFF}, 1'b0);
        chk_regs("a7");
        rq.push_back(8'h00);
        frame('{8'h07, 8'h00}, 1'b1);
        exp_wr(3'd2, 8'h5A);
        frame('{8'hFA, 8'h5A}, 1'b0);
        chk_regs("rsv");

        // async reset mid-frame while MISO shows reg3 MSB (0xA5)
        ss_n = 1'b0;
        #100;
        spi_bits(8'h03, 8, rx);
        #100;
        chk("mid_busy", {7'd0, busy}, 8'h01);
        chk("mid_miso", {7'd0, miso}, 8'h01);
        #3;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) model[i] = 8'h00;
        chk("arst_miso", {7'd0, miso}, 8'h00);
        chk("arst_busy", {7'd0, busy}, 8'h00);
        chk_regs("arst");
        #40;
        reset = 1'b1;
        ss_n = 1'b1;
        #300;
        chk("post_miso", {7'd0, miso}, 8'h00);
        chk_regs("post");

        chk("pending_wr", 8'(wq.size()), 8'h00);
        chk("pending_rd", 8'(rq.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
